// File: rtl/char_buffer_ctrl_pkg.sv
// Shared constants for the text-mode character overlay: screen geometry,
// the blank fill code and the control codes understood by the controller.
package char_buffer_ctrl_pkg;

    localparam int          TEXT_COLS  = 16;
    localparam int          TEXT_ROWS  = 16;
    localparam logic [7:0]  CHAR_BLANK = 8'h20;

    localparam logic [7:0]  CC_CR = 8'h0D;
    localparam logic [7:0]  CC_LF = 8'h0A;
    localparam logic [7:0]  CC_BS = 8'h08;
    localparam logic [7:0]  CC_FF = 8'h0C;

    // Printable ASCII range that is stored verbatim in the buffer.
    function automatic logic is_printable(input logic [7:0] c);
        return (c >= 8'h20) && (c <= 8'h7E);
    endfunction

endpackage

// File: rtl/char_buffer_ctrl_text_ram.sv
// Character-code store: simple dual-port RAM, synchronous read.
// A read and a write to the same address in one cycle return the old data.
module text_ram #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    // Write port and registered read port; non-blocking update gives read-first.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/char_buffer_ctrl.sv
// Text-mode screen controller for the character overlay. Interprets an ASCII
// byte stream, keeps the cursor, owns the buffer write port and serves the
// overlay's {row,col} read address with the stored character code.
module char_buffer_ctrl
    import char_buffer_ctrl_pkg::*;
#(
    parameter int         COLS  = TEXT_COLS,
    parameter int         ROWS  = TEXT_ROWS,
    parameter logic [7:0] BLANK = CHAR_BLANK
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [7:0]                            s_data,
    input  logic                                  s_valid,
    output logic                                  s_ready,
    input  logic [$clog2(ROWS)+$clog2(COLS)-1:0]  rd_addr,
    output logic [7:0]                            rd_code,
    output logic [$clog2(COLS)-1:0]               cursor_x,
    output logic [$clog2(ROWS)-1:0]               cursor_y,
    output logic                                  busy
);

    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam int AW = CW + RW;

    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
    localparam logic [AW-1:0] CNT_LAST = AW'((2**AW) - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CLR_ALL = 2'd1,
        ST_CLR_ROW = 2'd2
    } buf_state_t;

    buf_state_t     state_r, state_nx;
    logic [CW-1:0]  cx_r, cx_nx;
    logic [RW-1:0]  cy_r, cy_nx;
    logic [AW-1:0]  cnt_r, cnt_nx;
    logic           ready_r;
    logic           busy_r;
    logic           rd_en_r;

    logic           hs_s;
    logic           we_s;
    logic [AW-1:0]  waddr_s;
    logic [7:0]     wdata_s;
    logic [7:0]     rdata_s;

    assign hs_s = s_valid && ready_r;

    // Next-state, cursor and buffer-write decode for the clear sweeps and byte handling.
    always_comb begin
        state_nx = state_r;
        cx_nx    = cx_r;
        cy_nx    = cy_r;
        cnt_nx   = cnt_r;
        we_s     = 1'b0;
        waddr_s  = {cy_r, cx_r};
        wdata_s  = s_data;

        case (state_r)
            ST_CLR_ALL: begin
                we_s    = 1'b1;
                waddr_s = cnt_r;
                wdata_s = BLANK;
                if (cnt_r == CNT_LAST) begin
                    state_nx = ST_IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx   = cnt_r + AW'(1);
                end
            end

            ST_CLR_ROW: begin
                we_s    = 1'b1;
                waddr_s = {cy_r, cnt_r[CW-1:0]};
                wdata_s = BLANK;
                if (cnt_r[CW-1:0] == COL_LAST) begin
                    state_nx = ST_IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx   = cnt_r + AW'(1);
                end
            end

            ST_IDLE: begin
                cnt_nx = '0;
                if (hs_s) begin
                    if (is_printable(s_data)) begin
                        we_s = 1'b1;
                        if (cx_r != COL_LAST) begin
                            cx_nx = cx_r + CW'(1);
                        end else begin
                            // Line wrap: the new row is blanked before more text lands.
                            cx_nx    = '0;
                            cy_nx    = cy_r + RW'(1);
                            state_nx = ST_CLR_ROW;
                        end
                    end else if (s_data == CC_CR) begin
                        cx_nx = '0;
                    end else if (s_data == CC_LF) begin
                        cx_nx    = '0;
                        cy_nx    = cy_r + RW'(1);
                        state_nx = ST_CLR_ROW;
                    end else if (s_data == CC_BS) begin
                        if (cx_r != '0) begin
                            cx_nx   = cx_r - CW'(1);
                            we_s    = 1'b1;
                            waddr_s = {cy_r, cx_r - CW'(1)};
                            wdata_s = BLANK;
                        end else begin
                            cx_nx = cx_r;
                        end
                    end else if (s_data == CC_FF) begin
                        cx_nx    = '0;
                        cy_nx    = '0;
                        state_nx = ST_CLR_ALL;
                    end else begin
                        // Unknown control or non-ASCII byte: consumed without effect.
                        state_nx = ST_IDLE;
                    end
                end else begin
                    state_nx = ST_IDLE;
                end
            end

            default: begin
                state_nx = ST_CLR_ALL;
                cnt_nx   = '0;
            end
        endcase
    end

    // State, cursor, sweep counter and registered status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_CLR_ALL;
            cx_r    <= '0;
            cy_r    <= '0;
            cnt_r   <= '0;
            ready_r <= 1'b0;
            busy_r  <= 1'b1;
            rd_en_r <= 1'b0;
        end else begin
            state_r <= state_nx;
            cx_r    <= cx_nx;
            cy_r    <= cy_nx;
            cnt_r   <= cnt_nx;
            ready_r <= (state_nx == ST_IDLE);
            busy_r  <= (state_nx != ST_IDLE);
            rd_en_r <= 1'b1;
        end
    end

    text_ram #(
        .AW (AW),
        .DW (8)
    ) u_ram (
        .clk   (clk),
        .we    (we_s),
        .waddr (waddr_s),
        .wdata (wdata_s),
        .raddr (rd_addr),
        .rdata (rdata_s)
    );

    // The RAM data register has no reset; hold the read output at zero until
    // the first clock after reset has loaded it.
    assign rd_code  = rd_en_r ? rdata_s : 8'h00;
    assign s_ready  = ready_r;
    assign busy     = busy_r;
    assign cursor_x = cx_r;
    assign cursor_y = cy_r;

endmodule

// File: tb/tb_char_buffer_ctrl.sv
// Bench for char_buffer_ctrl: a queue-based screen model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_char_buffer_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] rd_addr;
    logic [7:0] rd_code;
    logic [3:0] cursor_x;
    logic [3:0] cursor_y;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

    char_buffer_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .rd_addr  (rd_addr),
        .rd_code  (rd_code),
        .cursor_x (cursor_x),
        .cursor_y (cursor_y),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // ---------------- behavioural screen model ----------------
    logic [7:0] m_mem   [256];
    bit         m_known [256];
    int         m_pend  [$];     // addresses still waiting to be blanked, one per cycle
    int         m_cx, m_cy;
    logic [7:0] m_rd;
    bit         m_rd_known;

    task automatic model_reset();
        m_pend.delete();
        for (int a = 0; a < 256; a++) m_pend.push_back(a);
        m_cx = 0;
        m_cy = 0;
        m_rd = 8'h00;
        m_rd_known = 1'b1;
    endtask

    task automatic model_step();
        int a;
        logic [7:0] b;
        m_rd_known = m_known[rd_addr];
        m_rd       = m_mem[rd_addr];
        if (m_pend.size() != 0) begin
            a = m_pend.pop_front();
            m_mem[a]   = 8'h20;
            m_known[a] = 1'b1;
        end else if (s_valid) begin
            b = s_data;
            if (b >= 8'h20 && b <= 8'h7E) begin
                m_mem[m_cy*16 + m_cx]   = b;
                m_known[m_cy*16 + m_cx] = 1'b1;
                if (m_cx < 15) m_cx++;
                else begin
                    m_cx = 0;
                    m_cy = (m_cy + 1) % 16;
                    for (int c = 0; c < 16; c++) m_pend.push_back(m_cy*16 + c);
                end
            end else if (b == 8'h0D) begin
                m_cx = 0;
            end else if (b == 8'h0A) begin
                m_cx = 0;
                m_cy = (m_cy + 1) % 16;
                for (int c = 0; c < 16; c++) m_pend.push_back(m_cy*16 + c);
            end else if (b == 8'h08) begin
                if (m_cx > 0) begin
                    m_cx--;
                    m_mem[m_cy*16 + m_cx]   = 8'h20;
                    m_known[m_cy*16 + m_cx] = 1'b1;
                end
            end else if (b == 8'h0C) begin
                m_cx = 0;
                m_cy = 0;
                for (int a2 = 0; a2 < 256; a2++) m_pend.push_back(a2);
            end
        end
    endtask

    task automatic model_compare();
        check("s_ready",  s_ready,  (m_pend.size() == 0));
        check("busy",     busy,     (m_pend.size() != 0));
        check("cursor_x", cursor_x, m_cx);
        check("cursor_y", cursor_y, m_cy);
        if (m_rd_known) check("rd_code", rd_code, m_rd);
    endtask

    // Per-cycle compare against the model, then advance it for the next edge.
    always @(negedge clk) begin
        if (rst) begin
            model_reset();
            model_compare();
        end else begin
            model_compare();
            model_step();
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic align();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit got = 1'b0;
        s_data  = b;
        s_valid = 1'b1;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (s_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) timeout("send_byte");
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic count_busy(output int n);
        bit done = 1'b0;
        n = 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (!busy) begin
                done = 1'b1;
                break;
            end
            n++;
        end
        if (!done) timeout("count_busy");
        align();
    endtask

    task automatic read_lit(input logic [7:0] a, input logic [7:0] exp, input string name);
        rd_addr = a;
        @(posedge clk);
        @(negedge clk);
        check(name, rd_code, exp);
        align();
    endtask

    task automatic sweep_reads();
        for (int a = 0; a < 256; a++) begin
            rd_addr = 8'(a);
            align();
        end
    endtask

    initial begin
        int n;
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = 8'h00;
        rd_addr = 8'h00;
        for (int a = 0; a < 256; a++) begin
            m_mem[a]   = 8'h00;
            m_known[a] = 1'b0;
        end

        // 1. reset release: 256-cycle init clear, then everything blank
        repeat (3) @(posedge clk);
        #1;
        check("t1_rst_rd_code", rd_code, 8'h00);
        rst = 1'b0;
        check("t1_ready_at_release", s_ready, 1'b0);
        check("t1_busy_at_release", busy, 1'b1);
        count_busy(n);
        check("t1_init_busy_cycles", n, 256);
        sweep_reads();
        read_lit(8'h37, 8'h20, "t1_blank_37");

        // 2. 'A','B'
        send_byte(8'h41);
        send_byte(8'h42);
        check("t2_cursor_x", cursor_x, 4'd2);
        check("t2_cursor_y", cursor_y, 4'd0);
        read_lit(8'h01, 8'h42, "t2_mem01");
        read_lit(8'h00, 8'h41, "t2_mem00");

        // 3. fill row 0, wrap, 17th byte held through the row clear
        send_byte(8'h0D);
        for (int i = 0; i < 16; i++) send_byte(8'(8'h61 + i));
        check("t3_wrap_x", cursor_x, 4'd0);
        check("t3_wrap_y", cursor_y, 4'd1);
        check("t3_wrap_busy", busy, 1'b1);
        send_byte(8'h71);
        check("t3_after17_x", cursor_x, 4'd1);
        read_lit(8'h10, 8'h71, "t3_mem10");
        read_lit(8'h0F, 8'h70, "t3_mem0f");
        read_lit(8'h11, 8'h20, "t3_mem11");

        // 4. move to row 15, LF wraps to row 0 and clears it
        for (int i = 0; i < 14; i++) send_byte(8'h0A);
        send_byte(8'h51);
        send_byte(8'h0D);
        check("t4_pre_y", cursor_y, 4'd15);
        send_byte(8'h0A);
        check("t4_lf_x", cursor_x, 4'd0);
        check("t4_lf_y", cursor_y, 4'd0);
        count_busy(n);
        check("t4_row_clear_cycles", n, 16);
        read_lit(8'h00, 8'h20, "t4_row0_blank");
        read_lit(8'hF0, 8'h51, "t4_row15_intact");
        read_lit(8'h10, 8'h71, "t4_row1_intact");

        // 5. backspace, ignored codes, form feed
        send_byte(8'h78);
        send_byte(8'h79);
        send_byte(8'h7A);
        send_byte(8'h08);
        check("t5_bs_x", cursor_x, 4'd2);
        read_lit(8'h02, 8'h20, "t5_bs_blank");
        read_lit(8'h01, 8'h79, "t5_bs_keep");
        send_byte(8'h0D);
        send_byte(8'h08);
        check("t5_bs0_x", cursor_x, 4'd0);
        read_lit(8'h00, 8'h78, "t5_bs0_keep");
        send_byte(8'h7F);
        send_byte(8'h01);
        send_byte(8'hFF);
        send_byte(8'h1B);
        check("t5_ignored_x", cursor_x, 4'd0);
        read_lit(8'h00, 8'h78, "t5_ignored_mem");
        send_byte(8'h41);
        send_byte(8'h0C);
        check("t5_ff_x", cursor_x, 4'd0);
        check("t5_ff_y", cursor_y, 4'd0);
        count_busy(n);
        check("t5_ff_cycles", n, 256);
        read_lit(8'h00, 8'h20, "t5_ff_blank");

        // 6. reset in the middle of a full clear restarts it
        send_byte(8'h52);
        send_byte(8'h0C);
        repeat (100) @(negedge clk);
        align();
        rst = 1'b1;
        align();
        check("t6_rst_busy", busy, 1'b1);
        check("t6_rst_ready", s_ready, 1'b0);
        align();
        rst = 1'b0;
        count_busy(n);
        check("t6_restart_cycles", n, 256);
        read_lit(8'hFF, 8'h20, "t6_mem_ff");
        sweep_reads();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
